// File: rtl/axi4_lite_reg_slave_pkg.sv
// Shared types for the AXI4-Lite register slave: response codes and the
// write/read channel state encodings.
package axi4_lite_reg_slave_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_WAIT_W,
    WR_WAIT_AW,
    WR_RESP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_DATA
  } rd_state_t;

endpackage

// File: rtl/axi4_lite_reg_bank.sv
// Register storage behind the slave: one byte-strobed write port, one
// combinational read port, flat export of all registers plus write strobes.
module axi4_lite_reg_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int IDX_W      = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           wr_en,
  input  logic [IDX_W-1:0]               wr_idx,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic [DATA_WIDTH/8-1:0]        wr_strb,
  input  logic [IDX_W-1:0]               rd_idx,
  output logic [DATA_WIDTH-1:0]          rd_data,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int STRB_W = DATA_WIDTH / 8;

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] mem;

  // Index comparisons per register keep non-power-of-two banks from ever
  // touching a slot that does not exist.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem      <= '0;
      wr_pulse <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        wr_pulse[i] <= wr_en && (wr_idx == IDX_W'(i));
        if (wr_en && (wr_idx == IDX_W'(i))) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (wr_strb[b]) mem[i][b*8 +: 8] <= wr_data[b*8 +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == IDX_W'(i)) rd_data = mem[i];
    end
  end

  assign regs = mem;

endmodule

// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite slave endpoint for a flat bank of read/write registers, with
// byte strobes, SLVERR on out-of-range addresses and AW/W in either order.
module axi4_lite_reg_slave
  import axi4_lite_reg_slave_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [DATA_WIDTH/8-1:0]        WSTRB,
  input  logic                           WVALID,
  output logic                           WREADY,
  output logic [1:0]                     BRESP,
  output logic                           BVALID,
  input  logic                           BREADY,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  function automatic logic addr_hit(input logic [ADDR_WIDTH-1:0] addr);
    return (addr >= BASE_ADDR) &&
           (((addr - BASE_ADDR) >> LSB) < ADDR_WIDTH'(NUM_REGS));
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] addr);
    return IDX_W'((addr - BASE_ADDR) >> LSB);
  endfunction

  wr_state_t               wr_state;
  rd_state_t               rd_state;
  logic [ADDR_WIDTH-1:0]   aw_addr_q;
  logic [DATA_WIDTH-1:0]   w_data_q;
  logic [STRB_W-1:0]       w_strb_q;
  logic                    aw_hs, w_hs, ar_hs;
  logic                    commit, commit_hit;
  logic [ADDR_WIDTH-1:0]   commit_addr;
  logic [DATA_WIDTH-1:0]   commit_data;
  logic [STRB_W-1:0]       commit_strb;
  logic [DATA_WIDTH-1:0]   rd_data;

  assign aw_hs = AWVALID && AWREADY;
  assign w_hs  = WVALID && WREADY;
  assign ar_hs = ARVALID && ARREADY;

  // The write commits on whichever edge completes the second handshake;
  // the half that arrived earlier comes from its holding register.
  always_comb begin
    commit      = 1'b0;
    commit_addr = AWADDR;
    commit_data = WDATA;
    commit_strb = WSTRB;
    case (wr_state)
      WR_IDLE:    commit = aw_hs && w_hs;
      WR_WAIT_W: begin
        commit      = w_hs;
        commit_addr = aw_addr_q;
      end
      WR_WAIT_AW: begin
        commit      = aw_hs;
        commit_data = w_data_q;
        commit_strb = w_strb_q;
      end
      default: ;
    endcase
  end

  assign commit_hit = addr_hit(commit_addr);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_state  <= WR_IDLE;
      AWREADY   <= 1'b0;
      WREADY    <= 1'b0;
      BVALID    <= 1'b0;
      BRESP     <= RESP_OKAY;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else if (commit) begin
      AWREADY  <= 1'b0;
      WREADY   <= 1'b0;
      BVALID   <= 1'b1;
      BRESP    <= commit_hit ? RESP_OKAY : RESP_SLVERR;
      wr_state <= WR_RESP;
    end else begin
      case (wr_state)
        WR_IDLE: begin
          if (aw_hs) begin
            aw_addr_q <= AWADDR;
            AWREADY   <= 1'b0;
            wr_state  <= WR_WAIT_W;
          end else if (w_hs) begin
            w_data_q <= WDATA;
            w_strb_q <= WSTRB;
            WREADY   <= 1'b0;
            wr_state <= WR_WAIT_AW;
          end else begin
            AWREADY <= 1'b1;
            WREADY  <= 1'b1;
          end
        end
        WR_RESP: begin
          if (BREADY) begin
            BVALID   <= 1'b0;
            AWREADY  <= 1'b1;
            WREADY   <= 1'b1;
            wr_state <= WR_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  // Read data is captured from the bank before any same-edge write lands,
  // so a colliding read returns the previous contents.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rd_state <= RD_IDLE;
      ARREADY  <= 1'b0;
      RVALID   <= 1'b0;
      RDATA    <= '0;
      RRESP    <= RESP_OKAY;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (ar_hs) begin
            ARREADY  <= 1'b0;
            RVALID   <= 1'b1;
            RDATA    <= addr_hit(ARADDR) ? rd_data : '0;
            RRESP    <= addr_hit(ARADDR) ? RESP_OKAY : RESP_SLVERR;
            rd_state <= RD_DATA;
          end else begin
            ARREADY <= 1'b1;
          end
        end
        RD_DATA: begin
          if (RREADY) begin
            RVALID   <= 1'b0;
            ARREADY  <= 1'b1;
            rd_state <= RD_IDLE;
          end
        end
      endcase
    end
  end

  axi4_lite_reg_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .IDX_W      (IDX_W)
  ) u_bank (
    .clock    (ACLK),
    .reset    (ARESET),
    .wr_en    (commit && commit_hit),
    .wr_idx   (addr_idx(commit_addr)),
    .wr_data  (commit_data),
    .wr_strb  (commit_strb),
    .rd_idx   (addr_idx(ARADDR)),
    .rd_data  (rd_data),
    .regs     (regs_o),
    .wr_pulse (wr_pulse_o)
  );

endmodule
